// File: rtl/vga_pic_gen.sv
// Bouncing-box picture generator for the VGA timing controller: registered RGB444 pixel
// one cycle after each pix_x/pix_y request. Define VGA_PIC_GRID_EN to overlay a grey grid.
module vga_pic_gen #(
   parameter int H_VALID  = 640,
   parameter int V_VALID  = 480,
   parameter int BOX_SIZE = 40,
   parameter int STEP     = 2,
   parameter int BAR_W    = 80
) (
   input  logic        vga_clk,
   input  logic        sys_rst,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic        mode,
   input  logic        pause,
   output logic [11:0] pix_data,
   output logic        frame_tick
);

   localparam logic [10:0] H_W    = 11'(H_VALID);
   localparam logic [10:0] V_W    = 11'(V_VALID);
   localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
   localparam logic [10:0] STEP_W = 11'(STEP);
   localparam logic [10:0] BAR_WW = 11'(BAR_W);
   localparam logic [10:0] H_LIM  = 11'(H_VALID - BOX_SIZE);
   localparam logic [10:0] V_LIM  = 11'(V_VALID - BOX_SIZE);
   localparam logic [9:0]  V_LAST = 10'(V_VALID - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MOVE_X,
      S_MOVE_Y,
      S_COLOR
   } state_t;

   typedef struct packed {
      logic        bounce;
      logic        dir;     // 0 = towards larger coordinates, 1 = towards zero
      logic [10:0] pos;
   } axis_t;

   state_t      state_q, state_d;
   logic [10:0] box_x_q, box_x_d;
   logic [10:0] box_y_q, box_y_d;
   logic        dir_x_q, dir_x_d;
   logic        dir_y_q, dir_y_d;
   logic        bounce_q, bounce_d;
   logic [2:0]  col_idx_q, col_idx_d;
   logic [9:0]  pix_y_d_q, pix_y_d_d;
   logic [11:0] pix_data_q, pix_data_d;
   logic        frame_tick_q, frame_tick_d;

   function automatic logic [11:0] palette(input logic [2:0] idx);
      logic [11:0] c;
      case (idx)
         3'd0:    c = 12'hF00;
         3'd1:    c = 12'h0F0;
         3'd2:    c = 12'h00F;
         3'd3:    c = 12'hFF0;
         3'd4:    c = 12'h0FF;
         3'd5:    c = 12'hF0F;
         3'd6:    c = 12'hFFF;
         default: c = 12'hF80;
      endcase
      return c;
   endfunction

   // Move one step along an axis, clamping onto the wall and reversing when it is reached.
   function automatic axis_t step_axis(input logic [10:0] pos, input logic dir,
                                       input logic [10:0] lim);
      axis_t r;
      r.bounce = 1'b0;
      r.dir    = dir;
      r.pos    = pos;
      if (!dir) begin
         if (pos + STEP_W >= lim) begin
            r.pos    = lim;
            r.dir    = 1'b1;
            r.bounce = 1'b1;
         end else begin
            r.pos = pos + STEP_W;
         end
      end else begin
         if (pos <= STEP_W) begin
            r.pos    = 11'd0;
            r.dir    = 1'b0;
            r.bounce = 1'b1;
         end else begin
            r.pos = pos - STEP_W;
         end
      end
      return r;
   endfunction

   axis_t x_next, y_next;
   assign x_next = step_axis(box_x_q, dir_x_q, H_LIM);
   assign y_next = step_axis(box_y_q, dir_y_q, V_LIM);

   // Falling edge of "last active line" in the request stream: once per frame.
   logic frame_end;
   assign frame_end = (pix_y_d_q == V_LAST) && (pix_y != V_LAST);

   logic [10:0] px, py;
   logic        in_box, in_active;
   logic [10:0] bar_num;
   logic [2:0]  bar_idx;
   logic [11:0] colour;

   assign px        = {1'b0, pix_x};
   assign py        = {1'b0, pix_y};
   assign in_box    = (px >= box_x_q) && (px < box_x_q + BOX_W) &&
                      (py >= box_y_q) && (py < box_y_q + BOX_W);
   assign in_active = (px < H_W) && (py < V_W);
   assign bar_num   = px / BAR_WW;
   assign bar_idx   = (bar_num > 11'd7) ? 3'd7 : bar_num[2:0];

   always_comb begin
      colour = 12'h000;
      if (in_box) begin
         colour = palette(col_idx_q);
      end else if (!in_active) begin
         colour = 12'h000;
`ifdef VGA_PIC_GRID_EN
      end else if ((pix_x[4:0] == 5'd0) || (pix_y[4:0] == 5'd0)) begin
         colour = 12'h888;
`endif
      end else if (mode) begin
         colour = palette(bar_idx);
      end else begin
         colour = 12'h000;
      end
   end

   always_comb begin
      state_d      = state_q;
      box_x_d      = box_x_q;
      box_y_d      = box_y_q;
      dir_x_d      = dir_x_q;
      dir_y_d      = dir_y_q;
      bounce_d     = bounce_q;
      col_idx_d    = col_idx_q;
      frame_tick_d = 1'b0;
      pix_y_d_d    = pix_y;
      pix_data_d   = colour;

      case (state_q)
         S_IDLE: begin
            if (frame_end && !pause) begin
               state_d = S_MOVE_X;
            end
         end
         S_MOVE_X: begin
            box_x_d  = x_next.pos;
            dir_x_d  = x_next.dir;
            bounce_d = bounce_q | x_next.bounce;
            state_d  = S_MOVE_Y;
         end
         S_MOVE_Y: begin
            box_y_d  = y_next.pos;
            dir_y_d  = y_next.dir;
            bounce_d = bounce_q | y_next.bounce;
            state_d  = S_COLOR;
         end
         S_COLOR: begin
            // A corner hit sets bounce twice but still advances the colour only once.
            if (bounce_q) begin
               col_idx_d = col_idx_q + 3'd1;
            end
            bounce_d     = 1'b0;
            frame_tick_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         state_q      <= S_IDLE;
         box_x_q      <= 11'd0;
         box_y_q      <= 11'd0;
         dir_x_q      <= 1'b0;
         dir_y_q      <= 1'b0;
         bounce_q     <= 1'b0;
         col_idx_q    <= 3'd0;
         pix_y_d_q    <= 10'd0;
         pix_data_q   <= 12'h000;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         box_x_q      <= box_x_d;
         box_y_q      <= box_y_d;
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
         bounce_q     <= bounce_d;
         col_idx_q    <= col_idx_d;
         pix_y_d_q    <= pix_y_d_d;
         pix_data_q   <= pix_data_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign pix_data   = pix_data_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_pic_gen.sv
// Bench for vga_pic_gen: default 640x480 instance plus a 640x640 instance for the corner bounce.
module tb_vga_pic_gen;

   logic        vga_clk = 1'b0;
   logic        sys_rst;
   logic [9:0]  pix_x, pix_y;
   logic        mode, pause;
   logic [11:0] pix_data;
   logic        frame_tick;
   logic [9:0]  sq_pix_x, sq_pix_y;
   logic [11:0] sq_pix_data;
   logic        sq_frame_tick;

   int tests_run = 0;
   int tests_failed = 0;

   logic [11:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 vga_clk = ~vga_clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   vga_pic_gen dut (
      .vga_clk    (vga_clk),
      .sys_rst    (sys_rst),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .mode       (mode),
      .pause      (pause),
      .pix_data   (pix_data),
      .frame_tick (frame_tick)
   );

   vga_pic_gen #(.H_VALID(640), .V_VALID(640)) dut_sq (
      .vga_clk    (vga_clk),
      .sys_rst    (sys_rst),
      .pix_x      (sq_pix_x),
      .pix_y      (sq_pix_y),
      .mode       (mode),
      .pause      (pause),
      .pix_data   (sq_pix_data),
      .frame_tick (sq_frame_tick)
   );

   // ---------------- reference model ----------------
   logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                            12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};
   int m_x[2], m_y[2], m_dx[2], m_dy[2], m_col[2];
   int m_h[2] = '{640, 640};
   int m_v[2] = '{480, 640};

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_x[d] = 0; m_y[d] = 0; m_dx[d] = 1; m_dy[d] = 1; m_col[d] = 0;
      end
   endtask

   task automatic axis_move(input int pos, input int dir, input int lim,
                            output int npos, output int ndir, output bit b);
      b = 1'b0;
      ndir = dir;
      if (dir > 0) begin
         if (pos + 2 >= lim) begin npos = lim; ndir = -1; b = 1'b1; end
         else npos = pos + 2;
      end else begin
         if (pos <= 2) begin npos = 0; ndir = 1; b = 1'b1; end
         else npos = pos - 2;
      end
   endtask

   task automatic model_update(input int d);
      int nx, ny, ndx, ndy;
      bit bx, by;
      axis_move(m_x[d], m_dx[d], m_h[d] - 40, nx, ndx, bx);
      axis_move(m_y[d], m_dy[d], m_v[d] - 40, ny, ndy, by);
      m_x[d] = nx; m_dx[d] = ndx;
      m_y[d] = ny; m_dy[d] = ndy;
      if (bx || by) m_col[d] = (m_col[d] + 1) % 8;
   endtask

   function automatic logic [11:0] model_colour(input int d, input int x, input int y,
                                                input logic m);
      int bar;
      if (x >= m_x[d] && x < m_x[d] + 40 && y >= m_y[d] && y < m_y[d] + 40)
         return pal[m_col[d]];
      if (x >= m_h[d] || y >= m_v[d]) return 12'h000;
`ifdef VGA_PIC_GRID_EN
      if (x % 32 == 0 || y % 32 == 0) return 12'h888;
`endif
      if (!m) return 12'h000;
      bar = x / 80;
      if (bar > 7) bar = 7;
      return pal[bar];
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Drive a request, queue its expected pixel, compare when the registered pixel appears.
   task automatic probe(input int d, input int x, input int y, input logic m,
                        input logic [11:0] e, input string nm);
      logic [11:0] got;
      if (d == 0) begin pix_x = 10'(x); pix_y = 10'(y); end
      else begin sq_pix_x = 10'(x); sq_pix_y = 10'(y); end
      mode = m;
      exp_q.push_back(e);
      @(posedge vga_clk); #1;
      got = (d == 0) ? pix_data : sq_pix_data;
      check(nm, {20'd0, got}, {20'd0, exp_q.pop_front()});
   endtask

   task automatic probe_model(input int d, input int x, input int y, input logic m,
                              input string nm);
      probe(d, x, y, m, model_colour(d, x, y, m), nm);
   endtask

   task automatic rand_probes(input int d, input int n);
      int x, y;
      int last;
      last = m_v[d] - 1;
      for (int i = 0; i < n; i++) begin
         x = $urandom_range(0, 1023);
         y = $urandom_range(0, 700);
         if (y == last) y = last - 1;
         probe_model(d, x, y, 1'($urandom_range(0, 1)), $sformatf("rand_d%0d_%0d_%0d", d, x, y));
      end
   endtask

   // Last active line then line 0: the update completes three edges after the event edge.
   task automatic frame_event(input int d, input logic p, input string nm);
      int hits, hit_at;
      logic t;
      if (d == 0) pix_y = 10'(m_v[0] - 1); else sq_pix_y = 10'(m_v[1] - 1);
      pause = p;
      @(posedge vga_clk); #1;
      if (d == 0) pix_y = 10'd0; else sq_pix_y = 10'd0;
      hits = 0;
      hit_at = -1;
      for (int k = 0; k < 6; k++) begin
         @(posedge vga_clk); #1;
         t = (d == 0) ? frame_tick : sq_frame_tick;
         if (t) begin hits++; hit_at = k; end
      end
      if (p) check({nm, "_paused_ticks"}, hits, 0);
      else   check({nm, "_tick_pos"}, {hits[15:0], hit_at[15:0]}, {16'd1, 16'd3});
      if (!p) model_update(d);
      pause = 1'b0;
   endtask

   typedef struct {
      int          x;
      int          y;
      logic        m;
      logic [11:0] e;
   } vec_t;

   vec_t vecs[14];

   // ---------------- test sequence ----------------
   initial begin
      int ticks;

      vecs[0]  = '{5,    5,   1'b0, 12'hF00};
      vecs[1]  = '{45,   5,   1'b0, 12'h000};
      vecs[2]  = '{39,   39,  1'b0, 12'hF00};
      vecs[3]  = '{40,   39,  1'b0, 12'h000};
      vecs[4]  = '{39,   40,  1'b0, 12'h000};
      vecs[5]  = '{100,  300, 1'b1, 12'h0F0};
      vecs[6]  = '{639,  300, 1'b1, 12'hF80};
      vecs[7]  = '{1022, 300, 1'b1, 12'h000};
      vecs[8]  = '{640,  100, 1'b1, 12'h000};
      vecs[9]  = '{79,   100, 1'b1, 12'hF00};
      vecs[10] = '{80,   100, 1'b1, 12'h0F0};
      vecs[11] = '{330,  200, 1'b1, 12'h0FF};
      vecs[12] = '{300,  480, 1'b1, 12'h000};
      vecs[13] = '{20,   20,  1'b1, 12'hF00};

      sys_rst = 1'b1;
      pix_x = 10'd5; pix_y = 10'd5;
      sq_pix_x = 10'd0; sq_pix_y = 10'd0;
      mode = 1'b0; pause = 1'b0;
      model_reset();
      repeat (3) @(posedge vga_clk);
      #1;
      check("rst_pix_data", {20'd0, pix_data}, 32'h000);
      check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
      sys_rst = 1'b0;

      foreach (vecs[i])
         probe(0, vecs[i].x, vecs[i].y, vecs[i].m, vecs[i].e, $sformatf("vec%0d", i));
      mode = 1'b0;

      frame_event(0, 1'b0, "frame1");
      probe(0, 41, 41, 1'b0, 12'hF00, "f1_in_41");
      probe(0, 1, 1, 1'b0, 12'h000, "f1_out_1");
      probe(0, 42, 41, 1'b0, 12'h000, "f1_out_42");

      for (int f = 2; f <= 220; f++) frame_event(0, 1'b0, $sformatf("frame%0d", f));
      probe(0, 440, 440, 1'b0, 12'h0F0, "f220_corner");
      probe(0, 439, 440, 1'b0, 12'h000, "f220_left");
      probe(0, 479, 470, 1'b0, 12'h0F0, "f220_far");
      probe(0, 480, 470, 1'b0, 12'h000, "f220_past");
      rand_probes(0, 8);

      for (int f = 221; f <= 300; f++) frame_event(0, 1'b0, $sformatf("frame%0d", f));
      probe(0, 600, 280, 1'b0, 12'h00F, "f300_corner");
      probe(0, 599, 280, 1'b0, 12'h000, "f300_left");
      probe(0, 639, 319, 1'b0, 12'h00F, "f300_far");
      probe(0, 639, 320, 1'b0, 12'h000, "f300_below");

      frame_event(0, 1'b0, "frame301");
      probe(0, 598, 278, 1'b0, 12'h00F, "f301_corner");
      probe(0, 597, 278, 1'b0, 12'h000, "f301_left");
      probe(0, 638, 278, 1'b0, 12'h000, "f301_right");
      probe(0, 597, 278, 1'b1, 12'hF80, "f301_bar7");
      rand_probes(0, 8);

      for (int f = 0; f < 5; f++) frame_event(0, 1'b1, $sformatf("pause%0d", f));
      probe(0, 598, 278, 1'b0, 12'h00F, "pause_corner");
      probe(0, 597, 278, 1'b0, 12'h000, "pause_left");
      frame_event(0, 1'b0, "unpause");
      probe(0, 596, 276, 1'b0, 12'h00F, "unpause_corner");
      probe(0, 595, 276, 1'b0, 12'h000, "unpause_left");
      probe(0, 636, 276, 1'b0, 12'h000, "unpause_right");

      // Reset while the FSM sits in S_MOVE_Y: no tick may follow and the box goes home.
      pix_y = 10'd479;
      @(posedge vga_clk); #1;
      pix_y = 10'd0;
      @(posedge vga_clk); #1;
      @(posedge vga_clk); #1;
      sys_rst = 1'b1;
      @(posedge vga_clk); #1;
      check("midrst_tick", {31'd0, frame_tick}, 32'd0);
      sys_rst = 1'b0;
      model_reset();
      ticks = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge vga_clk); #1;
         if (frame_tick) ticks++;
      end
      check("midrst_no_tick", ticks, 0);
      probe(0, 0, 0, 1'b0, 12'hF00, "midrst_origin");
      probe(0, 39, 39, 1'b0, 12'hF00, "midrst_far");
      probe(0, 40, 0, 1'b0, 12'h000, "midrst_out");
      rand_probes(0, 6);

      for (int f = 1; f <= 299; f++) frame_event(1, 1'b0, $sformatf("sq_frame%0d", f));
      probe(1, 598, 598, 1'b0, 12'hF00, "sq_f299");
      frame_event(1, 1'b0, "sq_frame300");
      probe(1, 600, 600, 1'b0, 12'h0F0, "sq_corner_col");
      probe(1, 599, 600, 1'b0, 12'h000, "sq_left");
      probe(1, 600, 599, 1'b0, 12'h000, "sq_above");
      rand_probes(1, 6);

      check("exp_q_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
